// File: rtl/xcheck_pkg.sv
// xcheck_pkg: shared state encoding and defaults for the X-check scheduler.
package xcheck_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_ARMED  = 2'd2,
      S_HALT   = 2'd3
   } state_e;

   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/xcheck_detect.sv
// xcheck_detect: combinational X/Z detect for one qualified channel.
module xcheck_detect #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_vld,
   input  logic [DATA_WIDTH-1:0] i_dat,
   output logic                  o_fail
);

   // An unknown qualifier is itself a failure; data only matters when qualified.
   assign o_fail = $isunknown(i_vld) ||
                   ((i_vld === 1'b1) && $isunknown(^i_dat));

endmodule

// File: rtl/xcheck_sched.sv
// xcheck_sched: simulation-only X checker with warm-up, capture and halt.
// Define XCHECK_MSG_EN to print an $error per failing channel.
module xcheck_sched
   import xcheck_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int N_CH        = 4,
   parameter int WARMUP      = 8,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int HALT_ON_ERR = 0,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_i,
   input  logic                       clr_i,
   input  logic [N_CH-1:0]            vld_i,
   input  logic [N_CH*DATA_WIDTH-1:0] dat_i,
   output logic [1:0]                 state_o,
   output logic                       armed_o,
   output logic                       err_o,
   output logic [CNT_W-1:0]           err_cnt_o,
   output logic                       first_vld_o,
   output logic [CH_W-1:0]            first_ch_o,
   output logic [N_CH-1:0]            sticky_o
);

   localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   state_e            r_state;
   state_e            w_nxt;
   logic [WC_W-1:0]   r_wcnt;
   logic [WC_W-1:0]   w_wcnt_nxt;
   logic              r_err;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_fvld;
   logic [CH_W-1:0]   r_fch;
   logic [N_CH-1:0]   r_sticky;
   logic [N_CH-1:0]   w_raw;
   logic [N_CH-1:0]   w_fail;
   logic              w_hit;
   logic [CH_W-1:0]   w_low;

   for (genvar g = 0; g < N_CH; g++) begin : g_det
      xcheck_detect #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_det (
         .i_vld  (vld_i[g]),
         .i_dat  (dat_i[g*DATA_WIDTH +: DATA_WIDTH]),
         .o_fail (w_raw[g])
      );
   end

   assign w_fail = w_raw & {N_CH{r_state == S_ARMED}};
   // A clear in the same cycle discards the failure entirely.
   assign w_hit  = (|w_fail) && !clr_i;

   always_comb begin
      w_low = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (w_fail[k]) w_low = CH_W'(k);
      end
   end

   always_comb begin
      w_nxt      = r_state;
      w_wcnt_nxt = r_wcnt;
      unique case (r_state)
         S_IDLE: begin
            if (en_i) w_nxt = (WARMUP == 0) ? S_ARMED : S_WARMUP;
         end
         S_WARMUP: begin
            if (!en_i) begin
               w_nxt      = S_IDLE;
               w_wcnt_nxt = '0;
            end else if (r_wcnt == WC_W'(WARMUP - 1)) begin
               w_nxt      = S_ARMED;
               w_wcnt_nxt = '0;
            end else begin
               w_wcnt_nxt = r_wcnt + 1'b1;
            end
         end
         S_ARMED: begin
            if (!en_i)                          w_nxt = S_IDLE;
            else if (HALT_ON_ERR != 0 && w_hit) w_nxt = S_HALT;
         end
         S_HALT: begin
            if (clr_i) w_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_wcnt   <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_fvld   <= 1'b0;
         r_fch    <= '0;
         r_sticky <= '0;
      end else begin
         r_state <= w_nxt;
         r_wcnt  <= w_wcnt_nxt;
         if (clr_i) begin
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_fvld   <= 1'b0;
            r_fch    <= '0;
            r_sticky <= '0;
         end else begin
            r_err <= w_hit;
            if (w_hit) begin
               if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
               r_sticky <= r_sticky | w_fail;
               if (!r_fvld) begin
                  r_fvld <= 1'b1;
                  r_fch  <= w_low;
               end
            end
         end
      end
   end

`ifdef XCHECK_MSG_EN
   always @(posedge clk) begin
      if (!rst && !clr_i) begin
         for (int k = 0; k < N_CH; k++) begin
            if (w_fail[k]) $error("xcheck: channel %0d unknown at %0t", k, $time);
         end
      end
   end
`endif

   assign state_o     = r_state;
   assign armed_o     = (r_state == S_ARMED);
   assign err_o       = r_err;
   assign err_cnt_o   = r_cnt;
   assign first_vld_o = r_fvld;
   assign first_ch_o  = r_fch;
   assign sticky_o    = r_sticky;

endmodule

// File: tb/tb_xcheck_sched.sv
// tb_xcheck_sched: directed checks for xcheck_sched (warm-up, capture, halt).
// Failure expectations depend on whether the simulator keeps X values.
module tb_xcheck_sched;

   localparam int DW = 32;
   localparam int NC = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic           a_en, a_clr;
   logic [NC-1:0]  a_vld;
   logic [NC*DW-1:0] a_dat;
   logic [1:0]     a_state;
   logic           a_armed, a_err, a_fvld;
   logic [1:0]     a_cnt;
   logic [1:0]     a_fch;
   logic [NC-1:0]  a_sticky;

   logic           b_en, b_clr;
   logic [NC-1:0]  b_vld;
   logic [NC*DW-1:0] b_dat;
   logic [1:0]     b_state;
   logic           b_armed, b_err, b_fvld;
   logic [15:0]    b_cnt;
   logic [1:0]     b_fch;
   logic [NC-1:0]  b_sticky;

   xcheck_sched #(
      .DATA_WIDTH(DW), .N_CH(NC), .WARMUP(8), .CNT_W(2), .HALT_ON_ERR(0)
   ) u_a (
      .clk(clk), .rst(rst), .en_i(a_en), .clr_i(a_clr),
      .vld_i(a_vld), .dat_i(a_dat),
      .state_o(a_state), .armed_o(a_armed), .err_o(a_err),
      .err_cnt_o(a_cnt), .first_vld_o(a_fvld), .first_ch_o(a_fch),
      .sticky_o(a_sticky)
   );

   xcheck_sched #(
      .DATA_WIDTH(DW), .N_CH(NC), .WARMUP(0), .CNT_W(16), .HALT_ON_ERR(1)
   ) u_b (
      .clk(clk), .rst(rst), .en_i(b_en), .clr_i(b_clr),
      .vld_i(b_vld), .dat_i(b_dat),
      .state_o(b_state), .armed_o(b_armed), .err_o(b_err),
      .err_cnt_o(b_cnt), .first_vld_o(b_fvld), .first_ch_o(b_fch),
      .sticky_o(b_sticky)
   );

   int checks   = 0;
   int failures = 0;
   bit fs;
   logic probe;
   int n;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      probe = 1'bx;
      fs    = $isunknown(probe);

      rst = 1'b1;
      a_en = 1'b1; a_clr = 1'b1; a_vld = '0; a_dat = '0;
      b_en = 1'b1; b_clr = 1'b1; b_vld = '0; b_dat = '0;
      step(); step();
      chk("rst_state_a", 32'(a_state), 32'd0);
      chk("rst_armed_a", 32'(a_armed), 32'd0);
      chk("rst_err_a",   32'(a_err),   32'd0);
      chk("rst_cnt_a",   32'(a_cnt),   32'd0);
      chk("rst_flags_a", {27'd0, a_fvld, a_sticky}, 32'd0);
      chk("rst_state_b", 32'(b_state), 32'd0);

      rst = 1'b0; a_clr = 1'b0; b_clr = 1'b0; b_en = 1'b0;
      step();
      n = 1;
      chk("warm_state1", 32'(a_state), 32'd1);
      a_vld = 4'b0001;
      a_dat[3] = 1'bx;
      step();
      n++;
      a_vld = '0;
      chk("warm_x_err", 32'(a_err), 32'd0);
      while (!a_armed && n < 20) begin
         step();
         n++;
      end
      chk("arm_latency", 32'(n), 32'd9);
      chk("arm_state",   32'(a_state), 32'd2);
      chk("warm_x_cnt",  32'(a_cnt), 32'd0);

      step(); step();
      chk("novld_err", 32'(a_err), 32'd0);
      chk("novld_cnt", 32'(a_cnt), 32'd0);

      a_dat = '0;
      a_vld = 4'b0100;
      a_dat[2*DW+7] = 1'bx;
      step();
      a_dat = '0;
      chk("ch2_err",    32'(a_err),    fs ? 32'd1 : 32'd0);
      chk("ch2_cnt",    32'(a_cnt),    fs ? 32'd1 : 32'd0);
      chk("ch2_fch",    32'(a_fch),    fs ? 32'd2 : 32'd0);
      chk("ch2_fvld",   32'(a_fvld),   fs ? 32'd1 : 32'd0);
      chk("ch2_sticky", 32'(a_sticky), fs ? 32'h4 : 32'h0);
      step();
      chk("ch2_pulse",  32'(a_err),    32'd0);

      a_clr = 1'b1;
      step();
      a_clr = 1'b0;
      chk("clr_cnt",   32'(a_cnt), 32'd0);
      chk("clr_flags", {27'd0, a_fvld, a_sticky}, 32'd0);
      chk("clr_state", 32'(a_state), 32'd2);

      a_vld = 4'b1010;
      a_dat[1*DW+0]  = 1'bx;
      a_dat[3*DW+31] = 1'bz;
      step();
      a_dat = '0;
      chk("ch13_cnt",    32'(a_cnt),    fs ? 32'd1 : 32'd0);
      chk("ch13_fch",    32'(a_fch),    fs ? 32'd1 : 32'd0);
      chk("ch13_sticky", 32'(a_sticky), fs ? 32'ha : 32'h0);

      a_clr = 1'b1;
      a_vld = 4'b0001;
      a_dat[0] = 1'bx;
      step();
      a_clr = 1'b0;
      chk("clrwin_cnt",   32'(a_cnt), 32'd0);
      chk("clrwin_err",   32'(a_err), 32'd0);
      chk("clrwin_flags", {27'd0, a_fvld, a_sticky}, 32'd0);

      for (int i = 0; i < 5; i++) step();
      a_dat = '0;
      a_vld = '0;
      chk("sat_cnt",    32'(a_cnt),    fs ? 32'd3 : 32'd0);
      chk("sat_fch",    32'(a_fch),    32'd0);
      chk("sat_sticky", 32'(a_sticky), fs ? 32'h1 : 32'h0);

      a_en = 1'b0;
      step();
      chk("endrop_state", 32'(a_state), 32'd0);
      chk("endrop_cnt",   32'(a_cnt),   fs ? 32'd3 : 32'd0);
      a_en = 1'b1;
      step();
      chk("rewarm_state", 32'(a_state), 32'd1);
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      a_en = 1'b0;
      chk("midrst_state", 32'(a_state), 32'd0);
      chk("midrst_hist",  {25'd0, a_cnt, a_fvld, a_sticky}, 32'd0);

      b_en = 1'b1;
      step();
      chk("b_direct_arm", 32'(b_state), 32'd2);
      b_vld = 4'b0001;
      b_dat[9] = 1'bx;
      step();
      chk("b_halt_state", 32'(b_state), fs ? 32'd3 : 32'd2);
      chk("b_halt_err",   32'(b_err),   fs ? 32'd1 : 32'd0);
      b_dat = '0;
      b_vld = 4'b0010;
      b_dat[DW+4] = 1'bx;
      b_en = 1'b0;
      step();
      chk("b_frz_state",  32'(b_state),  fs ? 32'd3 : 32'd0);
      chk("b_frz_cnt",    32'(b_cnt),    fs ? 32'd1 : 32'd0);
      chk("b_frz_sticky", 32'(b_sticky), fs ? 32'h1 : 32'h0);
      b_dat = '0;
      b_vld = '0;
      b_clr = 1'b1;
      step();
      b_clr = 1'b0;
      chk("b_clr_state", 32'(b_state), 32'd0);
      chk("b_clr_flags", {11'd0, b_cnt, b_err, b_fvld, b_sticky}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xcheck_sched.md
XCHECK_SCHED -- requirements
Module: xcheck_sched

Interface
- REQ-001 Parameter: DATA_WIDTH, default 32, width of each monitored channel.
- REQ-002 Parameter: N_CH, default 4, number of monitored channels (>=1).
- REQ-003 Parameter: WARMUP, default 8, enabled cycles before checking is armed (0 allowed).
- REQ-004 Parameter: CNT_W, default 16, error counter width.
- REQ-005 Parameter: HALT_ON_ERR, default 0, 1 = freeze on first failure.
- REQ-006 Port: clk  in  1  single clock, all logic on posedge.
- REQ-007 Port: rst  in  1  synchronous, active-high reset.
- REQ-008 Port: en_i  in  1  global enable.
- REQ-009 Port: clr_i  in  1  clear counters, capture and sticky flags.
- REQ-010 Port: vld_i  in  N_CH  per-channel check-qualify.
- REQ-011 Port: dat_i  in  N_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- REQ-012 Port: state_o  out  2  current FSM state.
- REQ-013 Port: armed_o  out  1  high only in ARMED.
- REQ-014 Port: err_o  out  1  registered one-cycle failure pulse.
- REQ-015 Port: err_cnt_o  out  CNT_W  count of failing cycles.
- REQ-016 Port: first_vld_o  out  1  first-failure capture valid.
- REQ-017 Port: first_ch_o  out  max(1,$clog2(N_CH))  channel of first failure.
- REQ-018 Port: sticky_o  out  N_CH  per-channel ever-failed flags.

Function
- REQ-019 FSM states IDLE=0, WARMUP=1, ARMED=2, HALT=3; registered.
- REQ-020 IDLE->WARMUP when en_i=1; IDLE->ARMED directly if WARMUP=0.
- REQ-021 WARMUP: counter increments each cycle with en_i=1; ->ARMED after WARMUP enabled cycles (armed_o high in cycle WARMUP+1 after first en_i).
- REQ-022 en_i=0 in WARMUP or ARMED -> IDLE next cycle; warm-up counter cleared; err_cnt/capture/sticky retained.
- REQ-023 Channel k fails in a cycle when state=ARMED and (vld_i[k] is X/Z, or vld_i[k]=1 and ^dat_i slice k is not 0/1).
- REQ-024 Any failure: err_o=1 next cycle; err_cnt_o +1 per failing cycle (not per channel), saturating at 2^CNT_W-1.
- REQ-025 sticky_o[k] set on failure of channel k, held until clr_i or rst.
- REQ-026 First failure since clear: first_ch_o = lowest failing index, first_vld_o=1; later failures do not overwrite.
- REQ-027 HALT_ON_ERR=1: ARMED->HALT on any failure; HALT ignores en_i and inputs, outputs frozen.
- REQ-028 clr_i=1: next cycle err_cnt_o=0, sticky_o=0, first_vld_o=0, first_ch_o=0, err_o=0; HALT->IDLE; other states unchanged.
- REQ-029 clr_i and failure in same cycle: clear wins, failure discarded.
- REQ-030 No checking outside ARMED; X on dat_i in IDLE/WARMUP/HALT has no effect.

Reset
- REQ-031 rst=1 at posedge: state=IDLE, warm-up counter=0, all outputs 0; rst overrides en_i and clr_i.
- REQ-032 rst mid-WARMUP or mid-HALT restarts from IDLE with no retained history.

Configuration
- REQ-033 XCHECK_MSG_EN defined: each failing channel prints an $error naming channel index and time; undefined: no messages, counters/flags unchanged.
- REQ-034 Whole module simulation-only; X detection is not synthesized.

Structure
- REQ-035 Package xcheck_pkg holds the state enum and the CNT_W default constant.
- REQ-036 One sub-module xcheck_detect: combinational per-channel X detect (DATA_WIDTH), instantiated N_CH times.

Verification
- REQ-037 rst, en_i=1, WARMUP=8 -> armed_o rises exactly 9 cycles after en_i first high; state_o 0->1->2.
- REQ-038 ARMED, vld_i=4'b0100, ch2 has one X bit -> err_o pulse next cycle, err_cnt_o=1, first_ch_o=2, sticky_o=4'b0100.
- REQ-039 ARMED, ch1 and ch3 X same cycle -> err_cnt_o=1, first_ch_o=1, sticky_o=4'b1010.
- REQ-040 X on ch0 with vld_i[0]=0, or during WARMUP -> no err_o, err_cnt_o stays 0.
- REQ-041 HALT_ON_ERR=1, failure -> state_o=3, new X ignored; clr_i=1 -> IDLE, all flags 0.
- REQ-042 CNT_W=2, 5 failing cycles -> err_cnt_o saturates at 3.
